// File: rtl/ctrl_pkg.sv
// Shared types and encodings for the multicycle ARM-subset controller.
// States, ALU ops, data-processing commands, condition codes and mux selects.
package ctrl_pkg;

   localparam int FLAG_W  = 4;
   localparam int STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9
   } state_t;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;
   localparam logic [1:0] ALU_ORR = 2'b11;

   localparam logic [3:0] CMD_AND = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0010;
   localparam logic [3:0] CMD_ADD = 4'b0100;
   localparam logic [3:0] CMD_CMP = 4'b1010;
   localparam logic [3:0] CMD_ORR = 4'b1100;

   localparam logic [1:0] OP_DP  = 2'b00;
   localparam logic [1:0] OP_MEM = 2'b01;
   localparam logic [1:0] OP_BR  = 2'b10;
   localparam logic [1:0] OP_NOP = 2'b11;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;

   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   localparam logic [1:0] SRCB_RD2  = 2'b00;
   localparam logic [1:0] SRCB_IMM  = 2'b01;
   localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register and condition evaluation.
// ALU flags are captured in execute and committed in writeback.
module cond_unit
   import ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        cond,
   input  logic [FLAG_W-1:0] alu_flags,
   input  logic              capture,
   input  logic              update,
   input  logic              upd_nz,
   input  logic              upd_cv,
   output logic              cond_ex
);

   logic [FLAG_W-1:0] flags;
   logic [FLAG_W-1:0] held;
   logic n, z, c, v;

   assign {n, z, c, v} = flags;

   // Hold execute-cycle flags, commit selected fields in writeback
   always_ff @(posedge clk) begin
      if (rst) begin
         flags <= '0;
         held  <= '0;
      end else begin
         if (capture) held <= alu_flags;
         if (update && upd_nz) flags[3:2] <= held[3:2];
         if (update && upd_cv) flags[1:0] <= held[1:0];
      end
   end

   // Condition field against committed flags; 1111 behaves as AL
   always_comb begin
      cond_ex = 1'b1;
      case (cond)
         COND_EQ: cond_ex = z;
         COND_NE: cond_ex = ~z;
         COND_CS: cond_ex = c;
         COND_CC: cond_ex = ~c;
         COND_MI: cond_ex = n;
         COND_PL: cond_ex = ~n;
         COND_VS: cond_ex = v;
         COND_VC: cond_ex = ~v;
         COND_HI: cond_ex = c & ~z;
         COND_LS: cond_ex = ~c | z;
         COND_GE: cond_ex = (n == v);
         COND_LT: cond_ex = (n != v);
         COND_GT: cond_ex = ~z & (n == v);
         COND_LE: cond_ex = z | (n != v);
         default: cond_ex = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences ALU, memory port, register file and PC.
// Moore decode from the state register, strobes gated by handshake and reset.
module multicycle_ctrl
   import ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         Cond,
   input  logic [1:0]         Op,
   input  logic [5:0]         Funct,
   input  logic [3:0]         Rd,
   input  logic [FLAG_W-1:0]  ALUFlags,
   input  logic               mem_ready,
   output logic               PCWrite,
   output logic               AdrSrc,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               RegWrite,
   output logic [1:0]         ResultSrc,
   output logic               ALUSrcA,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         ALUControl,
   output logic [1:0]         ImmSrc,
   output logic [1:0]         RegSrc,
   output logic [STATE_W-1:0] state_dbg
);

   state_t     state;
   logic [3:0] cmd;
   logic       s_bit;
   logic [1:0] alu_op;
   logic       no_write;
   logic       upd_nz;
   logic       upd_cv;
   logic       cond_ex;
   logic       pc_dest;

   assign cmd     = Funct[4:1];
   assign s_bit   = Funct[0];
   assign pc_dest = (Rd == 4'd15);

   assign state_dbg = rst ? FETCH : state;
   assign ImmSrc    = rst ? 2'b00 : Op;
   assign RegSrc    = rst ? 2'b00 : {Op == OP_MEM, Op == OP_BR};

   cond_unit u_cond (
      .clk       (clk),
      .rst       (rst),
      .cond      (Cond),
      .alu_flags (ALUFlags),
      .capture   ((state == EXECR) || (state == EXECI)),
      .update    (state == ALUWB),
      .upd_nz    (upd_nz),
      .upd_cv    (upd_cv),
      .cond_ex   (cond_ex)
   );

   // Data-processing command to ALU op, write suppression and flag policy
   always_comb begin
      alu_op   = ALU_ADD;
      no_write = 1'b0;
      upd_nz   = 1'b0;
      upd_cv   = 1'b0;
      case (cmd)
         CMD_ADD: begin
            upd_nz = s_bit;
            upd_cv = s_bit;
         end
         CMD_SUB: begin
            alu_op = ALU_SUB;
            upd_nz = s_bit;
            upd_cv = s_bit;
         end
         CMD_AND: begin
            alu_op = ALU_AND;
            upd_nz = s_bit;
         end
         CMD_ORR: begin
            alu_op = ALU_ORR;
            upd_nz = s_bit;
         end
         CMD_CMP: begin
            alu_op   = ALU_SUB;
            no_write = 1'b1;
            upd_nz   = 1'b1;
            upd_cv   = 1'b1;
         end
         default: no_write = 1'b1;
      endcase
   end

   // State sequencing; memory states stall until mem_ready
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= FETCH;
      end else begin
         case (state)
            FETCH:   if (mem_ready) state <= DECODE;
            DECODE: begin
               if (!cond_ex) begin
                  state <= FETCH;
               end else begin
                  case (Op)
                     OP_MEM:  state <= MEMADR;
                     OP_DP:   state <= Funct[5] ? EXECI : EXECR;
                     OP_BR:   state <= BRANCH;
                     default: state <= FETCH;
                  endcase
               end
            end
            MEMADR:  state <= Funct[0] ? MEMRD : MEMWR;
            MEMRD:   if (mem_ready) state <= MEMWB;
            MEMWR:   if (mem_ready) state <= FETCH;
            EXECR:   state <= ALUWB;
            EXECI:   state <= ALUWB;
            default: state <= FETCH;
         endcase
      end
   end

   // Per-state control outputs, all forced low during reset
   always_comb begin
      PCWrite    = 1'b0;
      AdrSrc     = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = 1'b0;
      ALUSrcB    = SRCB_RD2;
      ALUControl = ALU_ADD;
      if (!rst) begin
         case (state)
            FETCH: begin
               ALUSrcA   = 1'b1;
               ALUSrcB   = SRCB_FOUR;
               ResultSrc = RES_ALURES;
               IRWrite   = mem_ready;
               PCWrite   = mem_ready;
            end
            DECODE: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_FOUR;
            end
            MEMADR:  ALUSrcB = SRCB_IMM;
            MEMRD:   AdrSrc = 1'b1;
            MEMWB: begin
               ResultSrc = RES_DATA;
               RegWrite  = 1'b1;
               PCWrite   = pc_dest;
            end
            MEMWR: begin
               AdrSrc   = 1'b1;
               MemWrite = 1'b1;
            end
            EXECR:   ALUControl = alu_op;
            EXECI: begin
               ALUSrcB    = SRCB_IMM;
               ALUControl = alu_op;
            end
            ALUWB: begin
               RegWrite = ~no_write;
               PCWrite  = pc_dest & ~no_write;
            end
            BRANCH: begin
               ALUSrcB   = SRCB_IMM;
               ResultSrc = RES_ALURES;
               PCWrite   = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus queues expected
// per-cycle outputs, a monitor compares them at the falling edge.
module tb_multicycle_ctrl;
   import ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] Cond = 4'h0;
   logic [1:0] Op = 2'b00;
   logic [5:0] Funct = 6'h0;
   logic [3:0] Rd = 4'h0;
   logic [3:0] ALUFlags = 4'h0;
   logic       mem_ready = 1'b1;

   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ALUSrcA;
   logic [1:0] ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
   logic [3:0] state_dbg;

   logic [19:0] act;
   logic [19:0] exp_q[$];
   int          id_q[$];
   int          checks = 0;
   int          errors = 0;
   int          nstep = 0;
   logic        pend = 1'b0;
   logic [31:0] pend_w = 32'h0;

   always #5 clk = ~clk;

   multicycle_ctrl dut (
      .clk        (clk),
      .rst        (rst),
      .Cond       (Cond),
      .Op         (Op),
      .Funct      (Funct),
      .Rd         (Rd),
      .ALUFlags   (ALUFlags),
      .mem_ready  (mem_ready),
      .PCWrite    (PCWrite),
      .AdrSrc     (AdrSrc),
      .MemWrite   (MemWrite),
      .IRWrite    (IRWrite),
      .RegWrite   (RegWrite),
      .ResultSrc  (ResultSrc),
      .ALUSrcA    (ALUSrcA),
      .ALUSrcB    (ALUSrcB),
      .ALUControl (ALUControl),
      .ImmSrc     (ImmSrc),
      .RegSrc     (RegSrc),
      .state_dbg  (state_dbg)
   );

   assign act = {state_dbg, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                 ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc};

   // Next instruction word, applied at the start of the next step
   task automatic load(input logic [31:0] w);
      pend_w = w;
      pend   = 1'b1;
   endtask

   task automatic step(input logic r, input logic rdy, input logic [3:0] fl,
                       input state_t st, input logic pcw, input logic adr,
                       input logic mw, input logic irw, input logic rw,
                       input logic [1:0] rs, input logic sa,
                       input logic [1:0] sb, input logic [1:0] alu);
      logic [3:0] side;
      @(posedge clk);
      #1;
      if (pend) begin
         Cond  = pend_w[31:28];
         Op    = pend_w[27:26];
         Funct = pend_w[25:20];
         Rd    = pend_w[15:12];
         pend  = 1'b0;
      end
      rst       = r;
      mem_ready = rdy;
      ALUFlags  = fl;
      side = r ? 4'b0000 : {Op, Op == 2'b01, Op == 2'b10};
      exp_q.push_back({st, pcw, adr, mw, irw, rw, rs, sa, sb, alu, side});
      id_q.push_back(nstep);
      nstep++;
   endtask

   task automatic f(input logic rdy);
      step(0, rdy, 4'h0, FETCH, rdy, 0, 0, rdy, 0, 2'b10, 1, 2'b10, 2'b00);
   endtask

   task automatic dc();
      step(0, 1, 4'h0, DECODE, 0, 0, 0, 0, 0, 2'b00, 1, 2'b10, 2'b00);
   endtask

   task automatic madr();
      step(0, 1, 4'h0, MEMADR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
   endtask

   task automatic br();
      step(0, 1, 4'h0, BRANCH, 1, 0, 0, 0, 0, 2'b10, 0, 2'b01, 2'b00);
   endtask

   // Monitor: one expected entry per clock cycle
   initial begin
      logic [19:0] e;
      int          id;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            id = id_q.pop_front();
            checks++;
            if (act !== e) begin
               errors++;
               $display("FAIL step%0d: got %h required %h", id, act, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // reset held two cycles
      step(1, 1, 4'h0, FETCH, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
      step(1, 1, 4'h0, FETCH, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);

      // ADD R3,R1,R2; ALUWB flags input differs from execute value
      load(32'hE0813002); f(1); dc();
      step(0, 1, 4'hF, EXECR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
      step(0, 1, 4'h8, ALUWB, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00);

      // CMP R1,R2 with Z from ALU, then BEQ taken
      load(32'hE1510002); f(1); dc();
      step(0, 1, 4'h4, EXECR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01);
      step(0, 1, 4'h0, ALUWB, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
      load(32'h0A000000); f(1); dc(); br();

      // LDR R2,[R1]: one fetch stall, three MEMRD stalls
      load(32'hE5912000); f(0); f(1); dc(); madr();
      for (int i = 0; i < 3; i++)
         step(0, 0, 4'h0, MEMRD, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
      step(0, 1, 4'h0, MEMRD, 0, 1, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
      step(0, 1, 4'h0, MEMWB, 0, 0, 0, 0, 1, 2'b01, 0, 2'b00, 2'b00);

      // STR R2,[R1]: two MEMWR stalls
      load(32'hE5812000); f(1); dc(); madr();
      for (int i = 0; i < 2; i++)
         step(0, 0, 4'h0, MEMWR, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00);
      step(0, 1, 4'h0, MEMWR, 0, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00);

      // ADD PC,R1,#4: immediate form writing R15
      load(32'hE281F004); f(1); dc();
      step(0, 1, 4'h0, EXECI, 0, 0, 0, 0, 0, 2'b00, 0, 2'b01, 2'b00);
      step(0, 1, 4'h0, ALUWB, 1, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00);

      // Unsupported cmd with S=1: no write, Z must survive
      load(32'hE0313002); f(1); dc();
      step(0, 1, 4'h0, EXECR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
      step(0, 1, 4'h0, ALUWB, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);

      // ADDNE with Z=1 skipped, then BEQ still taken
      load(32'h10813002); f(1); dc();
      load(32'h0A000000); f(1); dc(); br();

      // ADDS aborted by reset in EXECR; flags cleared so BEQ fails
      load(32'hE0913002); f(1); dc();
      step(1, 1, 4'hF, FETCH, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
      load(32'h0A000000); f(1); dc();

      // ADDS sets CV, ANDS sets NZ only: flags 0111
      load(32'hE0913002); f(1); dc();
      step(0, 1, 4'h3, EXECR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00);
      step(0, 1, 4'hC, ALUWB, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00);
      load(32'hE0113002); f(1); dc();
      step(0, 1, 4'h4, EXECR, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b10);
      step(0, 1, 4'h0, ALUWB, 0, 0, 0, 0, 1, 2'b00, 0, 2'b00, 2'b00);

      // BHI fails (Z=1), BVS taken (V kept)
      load(32'h8A000000); f(1); dc();
      load(32'h6A000000); f(1); dc(); br();

      repeat (3) @(posedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
